parity_check_rx: RTL and testbench

//  Receive side of the 7-bit even-parity link. Deserialises LSB-first frames of

---
 rtl/parity_check_rx.sv | 139 +++++++++++++
 tb/tb_parity_check_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_rx.sv
// Even-parity serial receiver: deserialises LSB-first frames, checks parity, strobes the word.
// Optional saturating parity-error counter enabled by defining PAR_ERR_CNT_EN.
module parity_check_rx #(
    parameter int DATA_W = 7,
    parameter int TMO    = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_vld,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              par_err,
    output logic              frame_abrt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int TC_W = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [BC_W-1:0] PAR_POS  = BC_W'(DATA_W);
    localparam logic [TC_W-1:0] TMO_LAST = TC_W'((TMO > 0) ? TMO - 1 : 0);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [TC_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              data_vld_reg, data_vld_next;
    logic              par_err_reg, par_err_next;
    logic              frame_abrt_reg, frame_abrt_next;
    logic              bit_wr;
    logic [BC_W-1:0]   bit_idx;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        data_out_next   = data_out_reg;
        data_vld_next   = 1'b0;
        par_err_next    = par_err_reg;
        frame_abrt_next = 1'b0;
        bit_wr          = 1'b0;
        bit_idx         = '0;
        case (state_reg)
            IDLE: begin
                if (sin_vld && sof) begin
                    bit_wr       = 1'b1;
                    bit_cnt_next = BC_W'(1);
                    tmo_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            default: begin
                if (sin_vld) begin
                    tmo_cnt_next = '0;
                    if (sof) begin
                        // A new start marker discards the partial frame and becomes bit 0.
                        frame_abrt_next = 1'b1;
                        bit_wr          = 1'b1;
                        bit_cnt_next    = BC_W'(1);
                    end else if (bit_cnt_reg == PAR_POS) begin
                        data_vld_next = 1'b1;
                        data_out_next = shift_reg;
                        par_err_next  = (^shift_reg) ^ sin;
                        bit_cnt_next  = '0;
                        state_next    = IDLE;
                    end else begin
                        bit_wr       = 1'b1;
                        bit_idx      = bit_cnt_reg;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else if (TMO != 0) begin
                    if (tmo_cnt_reg == TMO_LAST) begin
                        frame_abrt_next = 1'b1;
                        bit_cnt_next    = '0;
                        tmo_cnt_next    = '0;
                        state_next      = IDLE;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
        assign shift_next[gi] = (bit_wr && (bit_idx == BC_W'(gi))) ? sin : shift_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            data_vld_reg   <= 1'b0;
            par_err_reg    <= 1'b0;
            frame_abrt_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            data_vld_reg   <= data_vld_next;
            par_err_reg    <= par_err_next;
            frame_abrt_reg <= frame_abrt_next;
        end
    end

`ifdef PAR_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_reg;

    // Counts in the same edge as the strobe so err_cnt already includes the strobed word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (data_vld_next && par_err_next && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = '0;
`endif

    assign data_out   = data_out_reg;
    assign data_vld   = data_vld_reg;
    assign par_err    = par_err_reg;
    assign frame_abrt = frame_abrt_reg;

endmodule

// File: tb/tb_parity_check_rx.sv
// Scoreboard bench for parity_check_rx: directed cases plus random frames against a list-based model.
module tb_parity_check_rx;

    localparam int DATA_W = 7;
    localparam int TMO    = 16;
    localparam int CNT_W  = 2;
    localparam int ECNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sin = 1'b0;
    logic              sin_vld = 1'b0;
    logic              sof = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              par_err;
    logic              frame_abrt;
    logic [CNT_W-1:0]  err_cnt;

    parity_check_rx #(.DATA_W(DATA_W), .TMO(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
        .data_out(data_out), .data_vld(data_vld), .par_err(par_err),
        .frame_abrt(frame_abrt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit abrt;
        int data;
        bit perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // Reference model state: the bits collected so far for the current frame.
    bit   bits[$];
    bit   in_frame = 1'b0;
    int   idle = 0;
    int   exp_ecnt = 0;
    int   last_data = 0;
    bit   last_perr = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_abort();
        exp_t e;
        e.abrt = 1'b1; e.data = 0; e.perr = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic model(input bit v, input bit s, input bit b);
        if (!in_frame) begin
            if (v && s) begin
                bits.delete(); bits.push_back(b); in_frame = 1'b1; idle = 0;
            end
        end else if (v) begin
            idle = 0;
            if (s) begin
                push_abort();
                bits.delete(); bits.push_back(b);
            end else if (bits.size() == DATA_W) begin
                exp_t e;
                e.abrt = 1'b0; e.data = 0; e.perr = b;
                foreach (bits[i]) begin
                    e.data = e.data + (int'(bits[i]) << i);
                    e.perr = e.perr ^ bits[i];
                end
                exp_q.push_back(e);
                in_frame = 1'b0;
`ifdef PAR_ERR_CNT_EN
                if (e.perr && exp_ecnt < ECNT_MAX) exp_ecnt++;
`endif
            end else begin
                bits.push_back(b);
            end
        end else begin
            idle++;
            if (TMO != 0 && idle == TMO) begin
                push_abort();
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic step(input bit v, input bit s, input bit b);
        sin_vld = v; sof = s; sin = b;
        @(posedge clk);
        model(v, s, b);
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input bit p, input int gap);
        for (int i = 0; i <= DATA_W; i++) begin
            if (i > 0) repeat (gap) step(0, 0, 0);
            step(1, i == 0, (i == DATA_W) ? p : d[i]);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0; sin_vld = 1'b0; sof = 1'b0; sin = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_vld", int'(data_vld), 0);
        chk("rst_par_err", int'(par_err), 0);
        chk("rst_frame_abrt", int'(frame_abrt), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        exp_q.delete(); bits.delete();
        in_frame = 1'b0; idle = 0; exp_ecnt = 0; last_data = 0; last_perr = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("err_cnt", int'(err_cnt), exp_ecnt);
            if (data_vld && frame_abrt) begin
                chk("strobe_overlap", 1, 0);
            end else if (data_vld || frame_abrt) begin
                if (exp_q.size() == 0) begin
                    chk(data_vld ? "unexpected_data_vld" : "unexpected_frame_abrt", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind_abrt", int'(frame_abrt), int'(e.abrt));
                    if (!e.abrt && data_vld) begin
                        chk("data_out", int'(data_out), e.data);
                        chk("par_err", int'(par_err), int'(e.perr));
                        last_data = e.data;
                        last_perr = e.perr;
                    end
                    $display("txn %s data=%02h par_err=%0d err_cnt=%0d", e.abrt ? "ABRT" : "DATA",
                             data_out, par_err, err_cnt);
                end
            end else begin
                chk("data_out_hold", int'(data_out), last_data);
                chk("par_err_hold", int'(par_err), int'(last_perr));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        send_frame(7'h55, 1'b0, 0);
        send_frame(7'h55, 1'b1, 0);
        send_frame(7'h7F, 1'b1, 3);

        step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        send_frame(7'h01, 1'b1, 0);

        step(1, 1, 0); step(1, 0, 1); step(1, 0, 1);
        repeat (16) step(0, 0, 0);
        repeat (4) step(1, 0, 1);
        repeat (3) step(0, 0, 0);

        for (int k = 0; k < 5; k++) send_frame(7'(k * 19 + 3), ~^(7'(k * 19 + 3)), k % 2);
        repeat (2) step(0, 0, 0);

        step(1, 1, 1); step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
        do_reset();
        repeat (3) step(0, 0, 0);
        send_frame(7'h2A, 1'b1, 1);

        for (int f = 0; f < 250; f++) begin
            logic [DATA_W-1:0] d;
            bit p;
            d = DATA_W'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) step(1, 0, 1'($urandom));
            for (int i = 0; i <= DATA_W; i++) begin
                if (i > 0) begin
                    int g;
                    g = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 2);
                    repeat (g) step(0, 0, 0);
                end
                step(1, (i == 0) || ($urandom_range(0, 59) == 0), (i == DATA_W) ? p : d[i]);
            end
            repeat ($urandom_range(0, 2)) step(0, 0, 0);
        end

        repeat (TMO + 4) step(0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
